// File: rtl/vram_writer.sv
// Buffered CPU write port for the display VRAM: queues {address, data} writes
// in an ordered FIFO and drains them only in cycles the display fetch leaves free.
module vram_writer #(
  parameter int DEPTH = 4,   // power of two, 2..16
  parameter int AW    = 13,
  parameter int DW    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpuWr,
  input  logic [AW-1:0]            cpuA,
  input  logic [DW-1:0]            cpuD,
  output logic                     cpuWait,
  input  logic                     busy,
  output logic                     we,
  output logic [AW-1:0]            a,
  output logic [DW-1:0]            q,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_we;
  logic [AW-1:0]   r_a;
  logic [DW-1:0]   r_q;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic [LW-1:0]   w_level_nxt;
  entry_t          w_head;

  assign w_full  = (r_level == FULL_LEVEL);
  assign w_empty = (r_level == '0);
  assign w_pop   = !w_empty && !busy;
  // A full FIFO still accepts a write when the same edge pops the head.
  assign w_push  = cpuWr && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  assign cpuWait = cpuWr && w_full && busy;

  // Level is tracked explicitly: equal pointers are ambiguous between empty and full.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_we     <= 1'b0;
      r_a      <= '0;
      r_q      <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_we    <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_a      <= w_head.addr;
        r_q      <= w_head.data;
      end
    end
  end

  // NOTE: the storage array has no reset; level and pointers alone decide which
  // entries are valid, so clearing it would only cost flops and reset fan-out.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{addr: cpuA, data: cpuD};
    end
  end

  assign we    = r_we;
  assign a     = r_a;
  assign q     = r_q;
  assign level = r_level;

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer (DEPTH=4): vector table for latency, stall,
// fill and full push+pop, then reset, wrap and ordering sequences.
module tb_vram_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpuWr;
  logic [12:0] cpuA;
  logic [7:0]  cpuD;
  logic        cpuWait;
  logic        busy;
  logic        we;
  logic [12:0] a;
  logic [7:0]  q;
  logic [2:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        wr;
    logic [12:0] addr;
    logic [7:0]  data;
    logic        busy;
    logic        exp_wait;
    logic        exp_we;
    logic [12:0] exp_a;
    logic [7:0]  exp_q;
    logic [2:0]  exp_level;
  } vec_t;

  vec_t vecs[$];

  vram_writer #(.DEPTH(4), .AW(13), .DW(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .cpuWr   (cpuWr),
    .cpuA    (cpuA),
    .cpuD    (cpuD),
    .cpuWait (cpuWait),
    .busy    (busy),
    .we      (we),
    .a       (a),
    .q       (q),
    .level   (level)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [12:0] ad, input logic [7:0] d,
                     input logic bz, input logic ew, input logic ewe,
                     input logic [12:0] ea, input logic [7:0] eq, input logic [2:0] el);
    vec_t v;
    v = '{wr, ad, d, bz, ew, ewe, ea, eq, el};
    vecs.push_back(v);
  endtask

  // Inputs change after the falling edge; cpuWait is checked before the rising
  // edge and registered outputs 1 time unit after it.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clock);
    cpuWr = v.wr; cpuA = v.addr; cpuD = v.data; busy = v.busy;
    #1;
    check($sformatf("v%0d cpuWait", idx), cpuWait, v.exp_wait);
    @(posedge clock);
    #1;
    check($sformatf("v%0d we", idx), we, v.exp_we);
    check($sformatf("v%0d a", idx), a, v.exp_a);
    check($sformatf("v%0d q", idx), q, v.exp_q);
    check($sformatf("v%0d level", idx), level, v.exp_level);
  endtask

  task automatic drive(input logic wr, input logic [12:0] ad, input logic [7:0] d, input logic bz);
    @(negedge clock);
    cpuWr = wr; cpuA = ad; cpuD = d; busy = bz;
    @(posedge clock);
    #1;
  endtask

  int   sent;
  int   rcvd;
  int   cyc;
  int   m_level;
  logic b;
  logic m_pop;
  logic m_push;

  initial begin
    reset = 1'b0;
    cpuWr = 1'b1; cpuA = 13'h0123; cpuD = 8'h99; busy = 1'b1;

    // Reset state: outputs cleared, and cpuWait low because the FIFO is empty.
    #12;
    check("reset we", we, 1'b0);
    check("reset a", a, 13'h0);
    check("reset q", q, 8'h0);
    check("reset level", level, 3'd0);
    check("reset cpuWait", cpuWait, 1'b0);
    @(negedge clock);
    cpuWr = 1'b0; busy = 1'b0;
    reset = 1'b1;

    //   wr addr      data   busy wait we  a         q      level
    // Single write, busy low: visible on the VRAM port after the second edge.
    add(1, 13'h1800, 8'h47, 0,   0,   0,  13'h0000, 8'h00, 3'd1);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h1800, 8'h47, 3'd0);
    add(0, 13'h0000, 8'h00, 0,   0,   0,  13'h1800, 8'h47, 3'd0);
    // Stall and fill: four writes absorbed, the fifth waits while busy stays high.
    add(1, 13'h0000, 8'h11, 1,   0,   0,  13'h1800, 8'h47, 3'd1);
    add(1, 13'h0001, 8'h22, 1,   0,   0,  13'h1800, 8'h47, 3'd2);
    add(1, 13'h0002, 8'h33, 1,   0,   0,  13'h1800, 8'h47, 3'd3);
    add(1, 13'h0003, 8'h44, 1,   0,   0,  13'h1800, 8'h47, 3'd4);
    add(1, 13'h0004, 8'h55, 1,   1,   0,  13'h1800, 8'h47, 3'd4);
    add(1, 13'h0004, 8'h55, 1,   1,   0,  13'h1800, 8'h47, 3'd4);
    add(1, 13'h0004, 8'h55, 0,   0,   1,  13'h0000, 8'h11, 3'd4);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h0001, 8'h22, 3'd3);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h0002, 8'h33, 3'd2);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h0003, 8'h44, 3'd1);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h0004, 8'h55, 3'd0);
    add(0, 13'h0000, 8'h00, 0,   0,   0,  13'h0004, 8'h55, 3'd0);
    // Full with simultaneous push and pop; out-of-screen addresses pass unchanged.
    add(1, 13'h0100, 8'hA0, 1,   0,   0,  13'h0004, 8'h55, 3'd1);
    add(1, 13'h0101, 8'hA1, 1,   0,   0,  13'h0004, 8'h55, 3'd2);
    add(1, 13'h0102, 8'hA2, 1,   0,   0,  13'h0004, 8'h55, 3'd3);
    add(1, 13'h0103, 8'hA3, 1,   0,   0,  13'h0004, 8'h55, 3'd4);
    add(1, 13'h0104, 8'hA4, 0,   0,   1,  13'h0100, 8'hA0, 3'd4);
    add(1, 13'h0105, 8'hA5, 0,   0,   1,  13'h0101, 8'hA1, 3'd4);
    add(1, 13'h1B00, 8'hA6, 0,   0,   1,  13'h0102, 8'hA2, 3'd4);
    add(1, 13'h1FFF, 8'hA7, 0,   0,   1,  13'h0103, 8'hA3, 3'd4);
    add(0, 13'h0000, 8'h00, 1,   0,   0,  13'h0103, 8'hA3, 3'd4);
    add(1, 13'h00AA, 8'hB0, 1,   1,   0,  13'h0103, 8'hA3, 3'd4);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h0104, 8'hA4, 3'd3);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h0105, 8'hA5, 3'd2);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h1B00, 8'hA6, 3'd1);
    add(0, 13'h0000, 8'h00, 0,   0,   1,  13'h1FFF, 8'hA7, 3'd0);
    add(0, 13'h0000, 8'h00, 0,   0,   0,  13'h1FFF, 8'hA7, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Reset mid-operation with 3 entries held and a write on the VRAM port.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 13'(32'h0300 + i), 8'(32'hC0 + i), 1'b1);
    end
    drive(1'b0, 13'h0, 8'h0, 1'b0);
    check("pre-reset we", we, 1'b1);
    check("pre-reset level", level, 3'd3);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("mid reset we", we, 1'b0);
    check("mid reset a", a, 13'h0);
    check("mid reset q", q, 8'h0);
    check("mid reset level", level, 3'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 13'h0, 8'h0, 1'b0);
      check($sformatf("post-reset idle%0d we", i), we, 1'b0);
      check($sformatf("post-reset idle%0d level", i), level, 3'd0);
    end

    // Wrap and ordering: 40 writes, busy high for 4 of every 16 cycles.
    sent = 0; rcvd = 0; cyc = 0; m_level = 0;
    while (rcvd < 40 && cyc < 400) begin
      @(negedge clock);
      b = ((cyc % 16) < 4);
      busy  = b;
      cpuWr = (sent < 40);
      cpuA  = 13'(32'h1000 + sent);
      cpuD  = 8'(sent);
      #1;
      check("wrap cpuWait", cpuWait, cpuWr && (m_level == 4) && b);
      m_pop  = (m_level > 0) && !b;
      m_push = cpuWr && ((m_level < 4) || m_pop);
      @(posedge clock);
      #1;
      if (m_push) sent++;
      m_level = m_level + int'(m_push) - int'(m_pop);
      check("wrap we", we, m_pop);
      check("wrap level", level, 32'(m_level));
      if (we) begin
        check($sformatf("wrap q #%0d", rcvd), q, 8'(rcvd));
        check($sformatf("wrap a #%0d", rcvd), a, 13'(32'h1000 + rcvd));
        rcvd++;
      end
      cyc++;
    end
    check("wrap writes received", rcvd, 40);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 13'h0, 8'h0, 1'b0);
      check($sformatf("wrap tail%0d we", i), we, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
